// File: rtl/memory_bus_arbiter_pkg.sv
// Shared encodings for memory_bus_arbiter: FSM state values and requester IDs.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
package memory_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_BUSY = 2'b01,
      ARB_DONE = 2'b10
   } arb_state_t;

   localparam logic ARB_REQ_INSTR = 1'b0;
   localparam logic ARB_REQ_DATA  = 1'b1;

endpackage

// File: rtl/memory_bus_arbiter_grant_select.sv
// Combinational winner choice between the instruction and data requesters.
// A tie goes to the requester that did not win last; a lone request always wins.
module arb_grant_select
   import memory_bus_arbiter_pkg::*;
(
   input  logic i_instr_req,
   input  logic i_data_req,
   input  logic i_last_grant,
   output logic o_any,
   output logic o_winner
);

   always_comb begin
      o_any    = i_instr_req | i_data_req;
      o_winner = ARB_REQ_INSTR;
      if (i_instr_req && i_data_req) begin
         o_winner = ~i_last_grant;
      end else if (i_data_req) begin
         o_winner = ARB_REQ_DATA;
      end
   end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one memory port between instruction and data requesters, one transaction at a time.
// Build option ARB_ROUND_ROBIN_EN: alternate on ties instead of fixed data priority.
module memory_bus_arbiter
   import memory_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  instr_read,
   input  logic                  instr_write,
   input  logic [ADDR_WIDTH-1:0] instr_address,
   input  logic [DATA_WIDTH-1:0] instr_write_data,
   output logic [DATA_WIDTH-1:0] instr_read_data,
   output logic                  instr_response,
   input  logic                  data_read,
   input  logic                  data_write,
   input  logic [ADDR_WIDTH-1:0] data_address,
   input  logic [DATA_WIDTH-1:0] data_write_data,
   output logic [DATA_WIDTH-1:0] data_read_data,
   output logic                  data_response,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   input  logic                  mem_response,
   output logic                  grant,
   output logic                  busy,
   output arb_state_t            dbg_state
);

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   logic                  r_grant;
   logic                  r_op_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_instr_rdata;
   logic [DATA_WIDTH-1:0] r_data_rdata;
   logic                  w_instr_req;
   logic                  w_data_req;
   logic                  w_any;
   logic                  w_winner;
   logic                  w_last_grant;

   assign w_instr_req = instr_read | instr_write;
   assign w_data_req  = data_read  | data_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_rr_ptr;

   // Remembers the owner of the last completed transaction; abandoned ones do not count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rr_ptr <= ARB_REQ_INSTR;
      end else if (r_state == ARB_DONE) begin
         r_rr_ptr <= r_grant;
      end
   end

   assign w_last_grant = r_rr_ptr;
`else
   assign w_last_grant = ARB_REQ_INSTR;
`endif

   arb_grant_select u_grant_select (
      .i_instr_req  (w_instr_req),
      .i_data_req   (w_data_req),
      .i_last_grant (w_last_grant),
      .o_any        (w_any),
      .o_winner     (w_winner)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ARB_IDLE: if (w_any) w_next_state = ARB_BUSY;
         ARB_BUSY: if (mem_response) w_next_state = ARB_DONE;
         ARB_DONE: w_next_state = ARB_IDLE;
         default:  w_next_state = ARB_IDLE;
      endcase
   end

   // Request fields are frozen at grant so the owner may change them while BUSY.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_grant       <= ARB_REQ_INSTR;
         r_op_write    <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_instr_rdata <= '0;
         r_data_rdata  <= '0;
      end else begin
         if (r_state == ARB_IDLE && w_any) begin
            r_grant <= w_winner;
            if (w_winner == ARB_REQ_DATA) begin
               r_op_write <= data_write;
               r_addr     <= data_address;
               r_wdata    <= data_write_data;
            end else begin
               r_op_write <= instr_write;
               r_addr     <= instr_address;
               r_wdata    <= instr_write_data;
            end
         end
         if (r_state == ARB_BUSY && mem_response && !r_op_write) begin
            if (r_grant == ARB_REQ_DATA) begin
               r_data_rdata <= mem_read_data;
            end else begin
               r_instr_rdata <= mem_read_data;
            end
         end
      end
   end

   assign mem_read        = (r_state == ARB_BUSY) && !r_op_write;
   assign mem_write       = (r_state == ARB_BUSY) &&  r_op_write;
   assign mem_address     = r_addr;
   assign mem_write_data  = r_wdata;
   assign instr_response  = (r_state == ARB_DONE) && (r_grant == ARB_REQ_INSTR);
   assign data_response   = (r_state == ARB_DONE) && (r_grant == ARB_REQ_DATA);
   assign instr_read_data = r_instr_rdata;
   assign data_read_data  = r_data_rdata;
   assign grant           = r_grant;
   assign busy            = (r_state != ARB_IDLE);
   assign dbg_state       = r_state;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: reset, reads, writes, arbitration,
// mid-transaction reset and stray memory responses.
module tb_memory_bus_arbiter;
   import memory_bus_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          instr_read, instr_write, data_read, data_write;
   logic [AW-1:0] instr_address, data_address;
   logic [DW-1:0] instr_write_data, data_write_data;
   logic [DW-1:0] instr_read_data, data_read_data;
   logic          instr_response, data_response;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_write_data, mem_read_data;
   logic          mem_response;
   logic          grant, busy;
   arb_state_t    dbg_state;

   int total = 0;
   int bad   = 0;
   logic exp_grant [4];

   memory_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk              (clk),
      .reset            (reset),
      .instr_read       (instr_read),
      .instr_write      (instr_write),
      .instr_address    (instr_address),
      .instr_write_data (instr_write_data),
      .instr_read_data  (instr_read_data),
      .instr_response   (instr_response),
      .data_read        (data_read),
      .data_write       (data_write),
      .data_address     (data_address),
      .data_write_data  (data_write_data),
      .data_read_data   (data_read_data),
      .data_response    (data_response),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data),
      .mem_response     (mem_response),
      .grant            (grant),
      .busy             (busy),
      .dbg_state        (dbg_state)
   );

   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_state"}, dbg_state, ARB_IDLE);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_mem_rd"}, mem_read, 1'b0);
      chk({tag, "_mem_wr"}, mem_write, 1'b0);
      chk({tag, "_i_resp"}, instr_response, 1'b0);
      chk({tag, "_d_resp"}, data_response, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      instr_read = 1'b0; instr_write = 1'b0; instr_address = '0; instr_write_data = '0;
      data_read = 1'b1;  data_write = 1'b0;  data_address = 32'h300; data_write_data = '0;
      mem_read_data = '0; mem_response = 1'b0;

      // 1: reset held with a pending data read
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle_outputs("rst");
         chk("rst_grant", grant, 1'b0);
         chk("rst_addr", mem_address, 32'h0);
         chk("rst_wdata", mem_write_data, 32'h0);
         chk("rst_irdata", instr_read_data, 32'h0);
         chk("rst_drdata", data_read_data, 32'h0);
      end
      reset = 1'b1;
      tick();
      chk("t1_state", dbg_state, ARB_BUSY);
      chk("t1_grant", grant, 1'b1);
      chk("t1_mem_rd", mem_read, 1'b1);
      chk("t1_addr", mem_address, 32'h300);
      chk("t1_busy", busy, 1'b1);
      mem_response = 1'b1; mem_read_data = 32'hAAAA5555;
      tick();
      mem_response = 1'b0;
      chk("t1_done", dbg_state, ARB_DONE);
      chk("t1_d_resp", data_response, 1'b1);
      chk("t1_i_resp", instr_response, 1'b0);
      chk("t1_drdata", data_read_data, 32'hAAAA5555);
      chk("t1_mem_rd_drop", mem_read, 1'b0);
      chk("t1_busy_done", busy, 1'b1);
      data_read = 1'b0;
      tick();
      chk_idle_outputs("t1_end");

      // 2: instruction read, memory answers in the second BUSY cycle
      instr_read = 1'b1; instr_address = 32'h100;
      tick();
      chk("t2_grant", grant, 1'b0);
      chk("t2_mem_rd", mem_read, 1'b1);
      chk("t2_mem_wr", mem_write, 1'b0);
      chk("t2_addr", mem_address, 32'h100);
      tick();
      chk("t2_wait", mem_read, 1'b1);
      chk("t2_no_resp", instr_response, 1'b0);
      mem_response = 1'b1; mem_read_data = 32'hDEADBEEF;
      tick();
      mem_response = 1'b0;
      chk("t2_i_resp", instr_response, 1'b1);
      chk("t2_d_resp", data_response, 1'b0);
      chk("t2_irdata", instr_read_data, 32'hDEADBEEF);
      chk("t2_drdata_hold", data_read_data, 32'hAAAA5555);
      instr_read = 1'b0;
      tick();
      chk_idle_outputs("t2_end");

      // 3: data write; address/data changes while BUSY are ignored
      data_write = 1'b1; data_address = 32'h200; data_write_data = 32'h12345678;
      tick();
      chk("t3_grant", grant, 1'b1);
      chk("t3_mem_wr", mem_write, 1'b1);
      chk("t3_mem_rd", mem_read, 1'b0);
      chk("t3_wdata", mem_write_data, 32'h12345678);
      chk("t3_addr", mem_address, 32'h200);
      data_address = 32'h999; data_write_data = 32'hFFFF0000;
      tick();
      chk("t3_addr_latched", mem_address, 32'h200);
      chk("t3_wdata_latched", mem_write_data, 32'h12345678);
      mem_response = 1'b1; mem_read_data = 32'h00000055;
      tick();
      mem_response = 1'b0;
      chk("t3_d_resp", data_response, 1'b1);
      chk("t3_mem_wr_drop", mem_write, 1'b0);
      chk("t3_drdata_hold", data_read_data, 32'hAAAA5555);
      data_write = 1'b0;
      tick();
      chk_idle_outputs("t3_end");

      // read and write together from one requester: the write wins
      instr_read = 1'b1; instr_write = 1'b1; instr_address = 32'h40; instr_write_data = 32'h77;
      tick();
      chk("rw_mem_wr", mem_write, 1'b1);
      chk("rw_mem_rd", mem_read, 1'b0);
      chk("rw_wdata", mem_write_data, 32'h77);
      mem_response = 1'b1; mem_read_data = 32'h0BADF00D;
      tick();
      mem_response = 1'b0;
      chk("rw_i_resp", instr_response, 1'b1);
      chk("rw_irdata_hold", instr_read_data, 32'hDEADBEEF);
      instr_read = 1'b0; instr_write = 1'b0;
      tick();
      chk_idle_outputs("rw_end");

      // 4: both requesters read continuously for four transactions
`ifdef ARB_ROUND_ROBIN_EN
      exp_grant[0] = 1'b1; exp_grant[1] = 1'b0; exp_grant[2] = 1'b1; exp_grant[3] = 1'b0;
`else
      exp_grant[0] = 1'b1; exp_grant[1] = 1'b1; exp_grant[2] = 1'b1; exp_grant[3] = 1'b1;
`endif
      instr_read = 1'b1; instr_address = 32'h400;
      data_read  = 1'b1; data_address  = 32'h800;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("t4_grant%0d", k), grant, exp_grant[k]);
         chk($sformatf("t4_mem_rd%0d", k), mem_read, 1'b1);
         chk($sformatf("t4_addr%0d", k), mem_address, exp_grant[k] ? 32'h800 : 32'h400);
         mem_response = 1'b1; mem_read_data = 32'h1000 + k;
         tick();
         mem_response = 1'b0;
         chk($sformatf("t4_i_resp%0d", k), instr_response, !exp_grant[k]);
         chk($sformatf("t4_d_resp%0d", k), data_response, exp_grant[k]);
         chk($sformatf("t4_rdata%0d", k),
             exp_grant[k] ? data_read_data : instr_read_data, 32'h1000 + k);
         tick();
         chk($sformatf("t4_idle%0d", k), busy, 1'b0);
      end
      instr_read = 1'b0; data_read = 1'b0;
      tick();
      chk_idle_outputs("t4_end");

      // 5: reset during BUSY abandons the transaction; late response ignored
      instr_read = 1'b1; instr_address = 32'h500;
      tick();
      chk("t5_busy", mem_read, 1'b1);
      reset = 1'b0;
      tick();
      chk_idle_outputs("t5_rst");
      chk("t5_grant", grant, 1'b0);
      chk("t5_irdata", instr_read_data, 32'h0);
      reset = 1'b1; instr_read = 1'b0;
      mem_response = 1'b1; mem_read_data = 32'hCAFEF00D;
      tick();
      mem_response = 1'b0;
      chk_idle_outputs("t5_late");
      tick();
      chk_idle_outputs("t5_after");
      chk("t5_irdata_after", instr_read_data, 32'h0);

      // 6: spurious memory response in IDLE with no requests
      mem_response = 1'b1; mem_read_data = 32'h13579BDF;
      tick();
      mem_response = 1'b0;
      chk_idle_outputs("t6");
      tick();
      chk_idle_outputs("t6_after");
      chk("t6_irdata", instr_read_data, 32'h0);
      chk("t6_drdata", data_read_data, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
